pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Detects load-use hazards that forwarding cannot cover.
- Holds the pipeline while a multi-cycle EX operation (mult/div) runs.
- Kills the wrong-path fetch on a taken branch resolved in ID.
- Drives per-stage hold and bubble controls for the existing pipeline registers.

Parameters:
MC_LAT, 4, EX occupancy in cycles of a multi-cycle op; legal range 2..255.
CNT_W, 8, width of the multi-cycle down-counter; must hold MC_LAT-2.

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock, reset is synchronous and active-low
id_re1  in  1  ID reads rs
id_raddr1  in  5  ID rs address
id_re2  in  1  ID reads rt
id_raddr2  in  5  ID rt address
ex_load  in  1  instruction in EX is a load
ex_waddr  in  5  EX destination register
ex_mc_start  in  1  instruction in EX is multi-cycle; held high while it sits in EX
id_branch_taken  in  1  ID resolved a taken branch/jump
stall_o  out  6  hold bits: [0] PC, [1] IF_ID, [2] ID_EX input side/ID, [3] EX, [4] MEM, [5] WB
bubble_idex  out  1  load NOP into ID_EX this edge
bubble_exmem  out  1  load NOP into EX_MEM this edge
flush_ifid  out  1  load NOP into IF_ID this edge
mc_busy  out  1  multi-cycle op occupying EX
mc_done  out  1  one-cycle pulse: final EX cycle of multi-cycle op
stall_cycles  out  32  only with STALL_CNT_EN

Behaviour:
- State registers: state ∈ {RUN, MC_WAIT}, cnt[CNT_W-1:0]. Updated on the rising clk edge only.
- Reset: when rstn=0 at a clk edge: state←RUN, cnt←0.
- While rstn=0, all outputs are forced to 0 combinationally, independent of the other inputs.
- All outputs are combinational from state, cnt and current inputs. Zero-cycle detection latency.
- Load-use hit (luh):
  - luh = ex_load & ex_waddr≠0 & ((id_re1 & id_raddr1==ex_waddr) | (id_re2 & id_raddr2==ex_waddr)).
  - Register $0 never hazards.
- RUN, ex_mc_start=1:
  - stall_o=6'b001111, bubble_exmem=1, mc_busy=1.
  - Next state MC_WAIT, cnt←MC_LAT-2.
  - luh is ignored: ID is already held and bubble_idex=0.
- RUN, ex_mc_start=0, luh=1:
  - stall_o=6'b000111, bubble_idex=1. State stays RUN.
  - The stall lasts exactly one cycle: next cycle the load is in MEM and the MEM forward path covers it.
- RUN, otherwise: stall_o=0, no bubbles.
- MC_WAIT, cnt≠0: stall_o=6'b001111, bubble_exmem=1, mc_busy=1, cnt←cnt-1.
- MC_WAIT, cnt==0: stall_o=0, mc_busy=1, mc_done=1, next state RUN.
  - luh is evaluated normally in this cycle.
  - ex_mc_start is ignored in this cycle; it is sampled only in RUN.
- Occupancy check: EX holds the op for exactly MC_LAT cycles (start cycle + MC_LAT-2 wait cycles + done cycle).
- Branch: flush_ifid = id_branch_taken & ~stall_o[2].
  - While ID is held, the branch is suppressed and re-evaluated next cycle, when operands are valid.
- Simultaneous events: priority is multi-cycle > load-use > branch. stall_o is always a prefix-contiguous mask (000000, 000111, 001111).
- Reset mid-operation: rstn=0 in MC_WAIT at an edge aborts the op. The next cycle is RUN with cnt=0 and no mc_done pulse.

Optional Feature:
PIPE_HAZARD_STALL_CNT_EN:
- Defined: adds port stall_cycles[31:0].
  - Increments by 1 at each clk edge where stall_o[0]=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared to 0 by the synchronous reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset with rstn=0 for 2 cycles, ex_mc_start=1, ex_load=1 with a matching addr → all outputs 0. First cycle after rstn=1 with ex_mc_start=1 → stall_o=001111.
2. Load-use: ex_load=1, ex_waddr=5, id_re1=1, id_raddr1=5 → stall_o=000111, bubble_idex=1. Repeat with ex_waddr=0 or id_re1=0 → stall_o=0.
3. Multi-cycle, MC_LAT=4: ex_mc_start=1 at T0 held through T3 → stall_o=001111 and bubble_exmem=1 at T0–T2. At T3: stall_o=0, mc_done=1. At T4 with ex_mc_start=0 → mc_busy=0.
4. Branch: id_branch_taken=1 alone → flush_ifid=1. Together with a load-use hit → flush_ifid=0, stall_o=000111. Next cycle, hit cleared → flush_ifid=1.
5. Reset mid-op: MC_LAT=6, start at T0, rstn=0 at the T2 edge → T3 outputs 0, state RUN, mc_done never asserted.
6. With PIPE_HAZARD_STALL_CNT_EN: run scenario 3 followed by one load-use stall → stall_cycles=4. Preload near saturation (force) → counter holds at FFFFFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the hazard controller's pipeline-side signals into one interface.
//   master : the pipeline. It drives the ID/EX hazard sources and receives
//            the hold and bubble controls.
//   slave  : pipe_hazard_ctrl. It receives the sources and drives the controls.
// Signals:
//   id_re1/id_raddr1, id_re2/id_raddr2 : source registers read in ID
//   ex_load, ex_waddr                  : load in EX and its destination register
//   ex_mc_start                        : multi-cycle op in EX, held while it sits there
//   id_branch_taken                    : ID resolved a taken branch or jump
//   stall_o[5:0]                       : hold bits {WB,MEM,EX,ID,IF_ID,PC}
//   bubble_idex, bubble_exmem          : load a NOP into ID_EX / EX_MEM
//   flush_ifid                         : load a NOP into IF_ID
//   mc_busy, mc_done                   : multi-cycle occupancy and final-cycle pulse
//   stall_cycles[31:0]                 : present only when PIPE_HAZARD_STALL_CNT_EN
//                                        is defined
interface pipe_hazard_ctrl_if;
    logic       id_re1;
    logic [4:0] id_raddr1;
    logic       id_re2;
    logic [4:0] id_raddr2;
    logic       ex_load;
    logic [4:0] ex_waddr;
    logic       ex_mc_start;
    logic       id_branch_taken;
    logic [5:0] stall_o;
    logic       bubble_idex;
    logic       bubble_exmem;
    logic       flush_ifid;
    logic       mc_busy;
    logic       mc_done;
`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
        output id_re1, id_raddr1, id_re2, id_raddr2,
        output ex_load, ex_waddr, ex_mc_start, id_branch_taken,
        input  stall_o, bubble_idex, bubble_exmem, flush_ifid, mc_busy, mc_done
`ifdef PIPE_HAZARD_STALL_CNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  id_re1, id_raddr1, id_re2, id_raddr2,
        input  ex_load, ex_waddr, ex_mc_start, id_branch_taken,
        output stall_o, bubble_idex, bubble_exmem, flush_ifid, mc_busy, mc_done
`ifdef PIPE_HAZARD_STALL_CNT_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline (PC, IF_ID, ID_EX,
// EX_MEM, MEM_WB). It performs three jobs:
//   - holds the front end for one cycle on a load-use hazard,
//   - holds PC..EX while a multi-cycle EX op runs for MC_LAT cycles,
//   - kills the wrong-path fetch on a taken branch resolved in ID.
// All outputs are combinational from state, cnt and the current inputs.
// Every output is forced to 0 while rstn is low.
// Ports:
//   clk  : system clock
//   rstn : synchronous, active-low reset
//   hz   : pipe_hazard_ctrl_if.slave, carrying the hazard sources and the controls
// Parameters:
//   MC_LAT : EX occupancy of a multi-cycle op in cycles (2..255)
//   CNT_W  : down-counter width; it must hold MC_LAT-2
// Optional build macro:
//   PIPE_HAZARD_STALL_CNT_EN : adds hz.stall_cycles, a saturating count of
//                              cycles in which the PC was held
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic       luh;
    logic [5:0] stall;
    logic       bub_idex;
    logic       bub_exmem;
    logic       flush;
    logic       busy;
    logic       done;

    // Load-use hit. The MEM forward path cannot cover this hit, because the
    // load data is still a cycle away. Register $0 never creates a hazard.
    always_comb begin
        luh = hz.ex_load && (hz.ex_waddr != 5'd0) &&
              ((hz.id_re1 && (hz.id_raddr1 == hz.ex_waddr)) ||
               (hz.id_re2 && (hz.id_raddr2 == hz.ex_waddr)));
    end

    // Output decode. The priority order is multi-cycle, then load-use, then
    // branch. For this reason stall is always one of 000000, 000111 or 001111.
    always_comb begin
        stall     = 6'b000000;
        bub_idex  = 1'b0;
        bub_exmem = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (rstn) begin
            unique case (state)
                RUN: begin
                    if (hz.ex_mc_start) begin
                        // ID is already held behind EX. A load-use bubble
                        // here would drop the instruction in ID.
                        stall     = 6'b001111;
                        bub_exmem = 1'b1;
                        busy      = 1'b1;
                    end else if (luh) begin
                        stall    = 6'b000111;
                        bub_idex = 1'b1;
                    end
                end
                MC_WAIT: begin
                    busy = 1'b1;
                    if (cnt != '0) begin
                        stall     = 6'b001111;
                        bub_exmem = 1'b1;
                    end else begin
                        // Final EX cycle. The op's result moves on this edge,
                        // so ID hazards get normal checking. ex_mc_start is
                        // still high for the finishing op and is not a new start.
                        done = 1'b1;
                        if (luh) begin
                            stall    = 6'b000111;
                            bub_idex = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // While ID is held, the branch operands may be stale. The branch is
        // evaluated again on the cycle after ID releases.
        flush = rstn && hz.id_branch_taken && !stall[2];
    end

    // Sequencer state. A reset in MC_WAIT aborts the op and produces no mc_done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hz.ex_mc_start) begin
                        state <= MC_WAIT;
                        cnt   <= CNT_W'(MC_LAT - 2);
                    end
                end
                MC_WAIT: begin
                    if (cnt != '0) cnt   <= cnt - 1'b1;
                    else           state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign hz.stall_o      = stall;
    assign hz.bubble_idex  = bub_idex;
    assign hz.bubble_exmem = bub_exmem;
    assign hz.flush_ifid   = flush;
    assign hz.mc_busy      = busy;
    assign hz.mc_done      = done;

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Counts the clock edges at which the PC is held. The count saturates
    // at its maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (stall[0] && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign hz.stall_cycles = rstn ? stall_cnt : 32'd0;
`endif

endmodule
